// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
// Vector order walks {a,b} = 00, 11, 10, 01; truth tables are indexed by {a,b}.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [1:0] VEC_ORDER [4] = '{2'b00, 2'b11, 2'b10, 2'b01};

    localparam logic [3:0] TRUTH_NOR  = 4'b0001;
    localparam logic [3:0] TRUTH_NAND = 4'b0111;
    localparam logic [3:0] TRUTH_AND  = 4'b1000;
    localparam logic [3:0] TRUTH_OR   = 4'b1110;

endpackage

// File: rtl/gts_settle_timer.sv
// Settle down-counter: load has priority over decrement; zero_o reflects the registered count.
// Latency: new count visible one cycle after load/dec; no backpressure.
module gts_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// On-chip self-test for a 2-input gate: 4 vectors of SETTLE_CYCLES+1 cycles each; start ignored while busy.
// Optional GATE_TEST_STOP_ON_FAIL_EN: the first mismatching CHECK ends the run in DONE.
module gate_test_sequencer
    import gate_test_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [3:0] TRUTH         = TRUTH_NOR,
    parameter int         ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2:0]       fail_vec
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       ab_q, ab_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             fv_q, fv_d;
    logic [2:0]       fvec_q, fvec_d;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic             mismatch, last;

    gts_settle_timer #(.W(CNT_W)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(SETTLE_LOAD),
        .dec_i     (tmr_dec),
        .zero_o    (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ab_d     = ab_q;
        err_d    = err_q;
        pass_d   = pass_q;
        fv_d     = 1'b0;
        fvec_d   = fvec_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        last     = 1'b0;
        // Written as if/else so an X on y_in lands in the mismatch branch.
        if (y_in == TRUTH[ab_q]) begin
            mismatch = 1'b0;
        end else begin
            mismatch = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d    = '0;
                    fvec_d   = '0;
                    pass_d   = 1'b0;
                    idx_d    = 2'd0;
                    ab_d     = VEC_ORDER[0];
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    fvec_d = {ab_q, y_in};
                    fv_d   = 1'b1;
                end
                last = (idx_q == 2'd3);
`ifdef GATE_TEST_STOP_ON_FAIL_EN
                last = last | mismatch;
`endif
                if (last) begin
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end else begin
                    idx_d    = idx_q + 2'd1;
                    ab_d     = VEC_ORDER[idx_d];
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            ab_q    <= 2'b00;
            err_q   <= '0;
            pass_q  <= 1'b0;
            fv_q    <= 1'b0;
            fvec_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ab_q    <= ab_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
        end
    end

    assign a_out      = ab_q[1];
    assign b_out      = ab_q[0];
    assign busy       = (state_q == SETTLE) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: three instances (NOR/1, NAND/1, NOR/3 settle) with a queue scoreboard.
// Honours GATE_TEST_STOP_ON_FAIL_EN when building expectations.
module tb_gate_test_sequencer;

    typedef struct {
        logic [2:0] err;
        logic       pass;
        logic [2:0] fvec;
        logic [1:0] ab;
        int         nfv;
        int         lat;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start;
    logic [2:0] y_in, a_out, b_out, busy, done, pass, fail_valid;
    logic [2:0] err_count [3];
    logic [2:0] fail_vec [3];
    int         ymode [3];
    int         sel = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic [1:0] order [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
    logic [1:0] vq [$];
    res_t       rq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_test_sequencer u_nor (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .a_out(a_out[0]), .b_out(b_out[0]),
        .y_in(y_in[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err_count[0]), .fail_valid(fail_valid[0]), .fail_vec(fail_vec[0])
    );

    gate_test_sequencer #(.TRUTH(4'b0111)) u_nand (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .a_out(a_out[1]), .b_out(b_out[1]),
        .y_in(y_in[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err_count[1]), .fail_valid(fail_valid[1]), .fail_vec(fail_vec[1])
    );

    gate_test_sequencer #(.SETTLE_CYCLES(3)) u_slow (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .a_out(a_out[2]), .b_out(b_out[2]),
        .y_in(y_in[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(err_count[2]), .fail_valid(fail_valid[2]), .fail_vec(fail_vec[2])
    );

    // Gate models: mode 0 = healthy gate, 1 = stuck at 0, 2 = stuck at 1.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (ymode[i] == 1)      y_in[i] = 1'b0;
            else if (ymode[i] == 2) y_in[i] = 1'b1;
            else if (i == 1)        y_in[i] = ~(a_out[i] & b_out[i]);
            else                    y_in[i] = ~(a_out[i] | b_out[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic good(input int which, input logic [1:0] v);
        return (which == 1) ? ~(v[1] & v[0]) : ~(v[1] | v[0]);
    endfunction

    task automatic expect_run(input int s, input int mode);
        res_t r;
        logic [1:0] v;
        logic yv;
        bit stop;
        stop  = 1'b0;
        r.err = 3'd0; r.fvec = 3'd0; r.nfv = 0; r.lat = 4 * (s + 1); r.ab = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (!stop) begin
                v = order[i];
                vq.push_back(v);
                r.ab = v;
                yv = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : good(sel, v);
                if (yv != good(sel, v)) begin
                    r.err  = r.err + 3'd1;
                    r.fvec = {v, yv};
                    r.nfv++;
`ifdef GATE_TEST_STOP_ON_FAIL_EN
                    stop  = 1'b1;
                    r.lat = (i + 1) * (s + 1);
`endif
                end
            end
        end
        r.pass = (r.err == 3'd0);
        rq.push_back(r);
    endtask

    // Monitor: pops an expected vector on each new vector, a result on each rising done.
    logic       prev_busy = 1'b0, prev_done = 1'b0;
    logic [1:0] prev_ab = 2'b00;
    int         t0 = 0, nfv = 0;

    always @(negedge clk) begin
        logic [1:0] ab;
        res_t r;
        ab = {a_out[sel], b_out[sel]};
        if (busy[sel] && (!prev_busy || ab != prev_ab)) begin
            if (!prev_busy) begin
                t0  = cyc;
                nfv = 0;
            end
            if (vq.size() == 0) chk("vec_extra", 32'(vq.size()), 32'd1);
            else                chk("vec_order", 32'(ab), 32'(vq.pop_front()));
        end
        if (fail_valid[sel]) nfv++;
        if (done[sel] && !prev_done) begin
            if (rq.size() == 0) begin
                chk("done_extra", 32'(rq.size()), 32'd1);
            end else begin
                r = rq.pop_front();
                chk("err_count", 32'(err_count[sel]), 32'(r.err));
                chk("pass", 32'(pass[sel]), 32'(r.pass));
                chk("fail_vec", 32'(fail_vec[sel]), 32'(r.fvec));
                chk("final_ab", 32'(ab), 32'(r.ab));
                chk("fail_pulses", 32'(nfv), 32'(r.nfv));
                chk("done_latency", 32'(cyc - t0), 32'(r.lat));
            end
        end
        prev_busy = busy[sel];
        prev_done = done[sel];
        prev_ab   = ab;
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_a"},    32'(a_out[sel]), 32'd0);
        chk({tag, "_b"},    32'(b_out[sel]), 32'd0);
        chk({tag, "_busy"}, 32'(busy[sel]), 32'd0);
        chk({tag, "_done"}, 32'(done[sel]), 32'd0);
        chk({tag, "_pass"}, 32'(pass[sel]), 32'd0);
        chk({tag, "_fv"},   32'(fail_valid[sel]), 32'd0);
        chk({tag, "_err"},  32'(err_count[sel]), 32'd0);
        chk({tag, "_fvec"}, 32'(fail_vec[sel]), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (rq.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("results_seen", 32'(rq.size()), 32'd0);
        chk("vectors_seen", 32'(vq.size()), 32'd0);
    endtask

    task automatic run_one(input int s, input int which, input int mode);
        sel = which;
        ymode[which] = mode;
        do_reset();
        repeat (2) @(negedge clk);
        expect_run(s, mode);
        start[which] = 1'b1;
        @(negedge clk);
        start[which] = 1'b0;
        drain(80);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen, checked;
        rst_n = 1'b0;
        start = 3'b000;
        ymode = '{0, 0, 0};
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        run_one(1, 0, 0);   // healthy NOR
        run_one(1, 0, 1);   // NOR output stuck at 0
        run_one(1, 1, 2);   // NAND output stuck at 1

        // Long settle, start held high: restart from DONE with a now-healthy gate.
        sel = 2;
        ymode[2] = 1;
        do_reset();
        repeat (2) @(negedge clk);
        expect_run(3, 1);
        expect_run(3, 0);
        start[2] = 1'b1;
        seen = 1'b0;
        checked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (seen && !checked) begin
                chk("restart_err_clear", 32'(err_count[2]), 32'd0);
                chk("restart_busy", 32'(busy[2]), 32'd1);
                checked = 1'b1;
            end
            if (done[2] && !seen) begin
                seen = 1'b1;
                ymode[2] = 0;
            end
        end
        start[2] = 1'b0;
        drain(100);

        // Reset during the third vector's settle aborts the run without a done.
        sel = 0;
        ymode[0] = 0;
        do_reset();
        repeat (2) @(negedge clk);
        vq.push_back(2'b00);
        vq.push_back(2'b11);
        vq.push_back(2'b10);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_zero("abort");
        repeat (10) @(negedge clk);
        chk("abort_vectors", 32'(vq.size()), 32'd0);
        run_one(1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
- Hardware sequencer that exercises a 2-input logic gate under test, such as nor_gate, with all four input vectors and checks each output.
- Drives the gate's a/b inputs, waits a programmable settle time, samples y, compares it against a parameterised truth table and counts errors.
- Sits beside the gate instance as an on-chip self-test controller; it replaces the manual stimulus/check flow at block level.

Parameters:
- SETTLE_CYCLES, 1, cycles between applying a vector and entering CHECK; legal range >=1.
- TRUTH, 4'b0001, expected y indexed by {a,b}. Bit0 = {a,b}=00. The default is NOR.
- ERR_W, 3, err_count width; must hold 0..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level; sampled only in IDLE or DONE.
- a_out  out  1  drives gate input a.
- b_out  out  1  drives gate input b.
- y_in  in  1  gate output under test.
- busy  out  1  high in SETTLE or CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; high when err_count==0.
- err_count  out  ERR_W  mismatches in the current or last run; saturating.
- fail_valid  out  1  one-cycle pulse after a mismatching CHECK.
- fail_vec  out  3  {a,b,y_in} of the most recent mismatch; sticky until the next start.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low (rst_n).
- Reset values: state=IDLE; a_out, b_out, busy, done, pass, fail_valid = 0; err_count=0; fail_vec=0.
- A reset asserted mid-run takes effect at the next edge. The run is aborted and no done pulse is produced.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- Vector order, index 0..3: {a,b} = 00, 11, 10, 01. The index is a 2-bit register.
- IDLE/DONE with start=1 at an edge:
  - clear err_count, fail_vec and pass.
  - load vector 0 onto a_out/b_out.
  - load the settle counter with SETTLE_CYCLES-1.
  - go to SETTLE.
  - done drops on the same edge.
- SETTLE: decrement the counter each edge. When the counter is 0, go to CHECK.
- CHECK: at the edge, sample y_in and compare it with TRUTH[{a_out,b_out}].
  - On mismatch: err_count+1, saturating at 2^ERR_W-1; fail_vec<={a_out,b_out,y_in}; fail_valid=1 for the next cycle only.
  - If index==3: go to DONE. pass<=(err_count_next==0).
  - Otherwise: index+1, drive the next vector, reload the counter, go to SETTLE.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. done rises 4*(SETTLE_CYCLES+1) edges after the start edge; that is 8 edges for the default.
- a_out/b_out hold the last vector (01) in DONE and return to 00 only on reset.
- DONE: done=1 and pass valid, held until the next start or reset. A start in DONE restarts immediately.
- start while busy: ignored, no effect.
- y_in is sampled only in CHECK. X on y_in counts as a mismatch, matching the bench's !== semantics.

Optional Feature:
- Macro: GATE_TEST_STOP_ON_FAIL_EN.
- Defined: the first mismatching CHECK goes straight to DONE with err_count=1 and pass=0. Remaining vectors are not applied. a_out/b_out hold the failing vector.
- Undefined: all four vectors are always applied and err_count is the total number of mismatches.

Decomposition:
- Package gate_test_pkg holds:
  - state enum {IDLE, SETTLE, CHECK, DONE}.
  - vector-order constant array VEC_ORDER[4] = {2'b00, 2'b11, 2'b10, 2'b01}.
  - truth-table constants TRUTH_NOR=4'b0001, TRUTH_NAND=4'b0111, TRUTH_AND=4'b1000, TRUTH_OR=4'b1110.
- Sub-module gts_settle_timer holds the down-counter: load, decrement and zero flag. Everything else stays in the top module.

Test Plan:
- Good NOR connected, default params; start pulse at cycle 2 -> vectors 00, 11, 10, 01 seen on a_out/b_out; done at start edge+8; pass=1; err_count=0; fail_valid never high.
- y_in tied to 0 -> mismatch only on vector 00; err_count=1; pass=0; fail_vec=3'b000; exactly one fail_valid pulse.
- y_in tied to 1 with TRUTH=4'b0111 (NAND) -> mismatch only on vector 11; err_count=1; fail_vec=3'b111.
- SETTLE_CYCLES=3; start held high for 20 cycles -> done at edge+16. A restart occurs from DONE because start is still high. Run a second pass and check err_count is cleared at the restart.
- rst_n=0 for one edge during the third vector's SETTLE -> next cycle state IDLE, all outputs 0, no done; a new start runs a full clean sequence.
- With GATE_TEST_STOP_ON_FAIL_EN defined, y_in tied to 0 -> DONE after the first CHECK (edge+2); err_count=1; a_out=b_out=0.
